// File: rtl/rv_pkg.sv
// Shared RV32I decode constants, control bundle and immediate generator for the ID stage.
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic       esc_reg;
        logic       esc_mem;
        logic       ula_imm;
        logic       jump;
        logic       branch;
        logic       lui;
        logic       auipc;
        logic       jalr;
        logic       lw;
        logic [2:0] alu;
    } ctrl_t;

    // Shared by R-type and I-ALU; SLTU has no ALU op and is rejected by the decoder.
    function automatic logic [2:0] alu_of_f3(input logic [2:0] f3);
        case (f3)
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_XOR:  return ALU_XOR;
            F3_SRL:  return ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] ins);
        case (ins[6:0])
            OP_I, OP_LW, OP_JALR: return {{20{ins[31]}}, ins[31:20]};
            OP_SW:                return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BR:                return {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                                          ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:     return {ins[31:12], 12'b0};
            OP_JAL:               return {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                                          ins[30:21], 1'b0};
            default:              return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// Bundle of IF/ID, EX/WB feedback and ID_EX signals around the decode stage.
interface id_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcAdd4;
    logic            flush;
    logic            exLw;
    logic [4:0]      exRd;
    logic            wbWe;
    logic [4:0]      wbRd;
    logic [XLEN-1:0] wbData;

    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pcOut;
    logic [XLEN-1:0] pcAdd4Out;
    logic [4:0]      rd;
    logic            EscReg;
    logic            EscMem;
    logic            ulaImm;
    logic            jump;
    logic            Branch;
    logic            lui;
    logic            auiPc;
    logic            jalr;
    logic            lw;
    logic [2:0]      aluControl;
    logic            stall;
    logic [31:0]     stallCount;

    modport master (
        output instr, pc, pcAdd4, flush, exLw, exRd, wbWe, wbRd, wbData,
        input  rs1, rs2, imm, pcOut, pcAdd4Out, rd, EscReg, EscMem, ulaImm, jump, Branch,
               lui, auiPc, jalr, lw, aluControl, stall, stallCount
    );

    modport slave (
        input  instr, pc, pcAdd4, flush, exLw, exRd, wbWe, wbRd, wbData,
        output rs1, rs2, imm, pcOut, pcAdd4Out, rd, EscReg, EscMem, ulaImm, jump, Branch,
               lui, auiPc, jalr, lw, aluControl, stall, stallCount
    );

endinterface

// File: rtl/id_stage_regfile.sv
// 2-read/1-write register file with x0 tied to zero, write-first bypass and synchronous clear.
module id_stage_regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [$clog2(NREG)-1:0] raddr1_i,
    input  logic [$clog2(NREG)-1:0] raddr2_i,
    output logic [XLEN-1:0]         rdata1_o,
    output logic [XLEN-1:0]         rdata2_o,
    input  logic                    we_i,
    input  logic [$clog2(NREG)-1:0] waddr_i,
    input  logic [XLEN-1:0]         wdata_i
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr_i] = wdata_i;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle WB write is visible to the instruction currently decoding.
    always_comb begin
        if (raddr1_i == '0) begin
            rdata1_o = '0;
        end else if (wr_en && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end else begin
            rdata1_o = regs_q[raddr1_i];
        end

        if (raddr2_i == '0) begin
            rdata2_o = '0;
        end else if (wr_en && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end else begin
            rdata2_o = regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, immediates, register file, load-use stall and flush bubbles.
module id_stage
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    ctrl_t       ctrl_dec;
    ctrl_t       ctrl_out;
    logic        legal;
    logic        use_rs1;
    logic        use_rs2;
    logic        hazard;
    logic        bubble;
    logic [31:0] stall_count_d;
    logic [31:0] stall_count_q;

    assign opcode   = bus.instr[6:0];
    assign funct3   = bus.instr[14:12];
    assign funct7   = bus.instr[31:25];
    assign rs1_addr = bus.instr[19:15];
    assign rs2_addr = bus.instr[24:20];

    id_stage_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (bus.rs1),
        .rdata2_o (bus.rs2),
        .we_i     (bus.wbWe),
        .waddr_i  (bus.wbRd),
        .wdata_i  (bus.wbData)
    );

    always_comb begin
        ctrl_dec = '0;
        legal    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        case (opcode)
            OP_R: begin
                legal = ((funct7 == F7_BASE) && (funct3 != F3_SLTU)) ||
                        ((funct7 == F7_ALT) && (funct3 == F3_ADD));
                ctrl_dec.esc_reg = 1'b1;
                ctrl_dec.alu     = (funct7 == F7_ALT) ? ALU_SUB : alu_of_f3(funct3);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_I: begin
                // Shift-immediates need a clean funct7; the other I-ALU ops own those bits.
                if ((funct3 == F3_SLL) || (funct3 == F3_SRL)) begin
                    legal = (funct7 == F7_BASE);
                end else begin
                    legal = (funct3 != F3_SLTU);
                end
                ctrl_dec.esc_reg = 1'b1;
                ctrl_dec.ula_imm = 1'b1;
                ctrl_dec.alu     = alu_of_f3(funct3);
                use_rs1 = 1'b1;
            end
            OP_LW: begin
                legal = (funct3 == F3_LW);
                ctrl_dec.esc_reg = 1'b1;
                ctrl_dec.ula_imm = 1'b1;
                ctrl_dec.lw      = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_SW: begin
                legal = (funct3 == F3_SW);
                ctrl_dec.esc_mem = 1'b1;
                ctrl_dec.ula_imm = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_BR: begin
                legal = (funct3 == F3_BEQ);
                ctrl_dec.branch = 1'b1;
                ctrl_dec.alu    = ALU_SUB;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_JAL: begin
                legal = 1'b1;
                ctrl_dec.jump    = 1'b1;
                ctrl_dec.esc_reg = 1'b1;
            end
            OP_JALR: begin
                legal = (funct3 == F3_JALR);
                ctrl_dec.jalr    = 1'b1;
                ctrl_dec.jump    = 1'b1;
                ctrl_dec.esc_reg = 1'b1;
                ctrl_dec.ula_imm = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_LUI: begin
                legal = 1'b1;
                ctrl_dec.lui     = 1'b1;
                ctrl_dec.esc_reg = 1'b1;
            end
            OP_AUIPC: begin
                legal = 1'b1;
                ctrl_dec.auipc   = 1'b1;
                ctrl_dec.esc_reg = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            use_rs1 = 1'b0;
            use_rs2 = 1'b0;
        end
    end

    assign hazard = bus.exLw && (bus.exRd != 5'd0) &&
                    ((use_rs1 && (bus.exRd == rs1_addr)) || (use_rs2 && (bus.exRd == rs2_addr)));

    always_comb begin
        bubble   = reset || bus.flush || hazard || !legal;
        ctrl_out = bubble ? '0 : ctrl_dec;

        bus.EscReg     = ctrl_out.esc_reg;
        bus.EscMem     = ctrl_out.esc_mem;
        bus.ulaImm     = ctrl_out.ula_imm;
        bus.jump       = ctrl_out.jump;
        bus.Branch     = ctrl_out.branch;
        bus.lui        = ctrl_out.lui;
        bus.auiPc      = ctrl_out.auipc;
        bus.jalr       = ctrl_out.jalr;
        bus.lw         = ctrl_out.lw;
        bus.aluControl = ctrl_out.alu;
        bus.rd         = ctrl_out.esc_reg ? bus.instr[11:7] : 5'd0;
        bus.imm        = imm_gen(bus.instr);
        bus.pcOut      = bus.pc;
        bus.pcAdd4Out  = bus.pcAdd4;
        // Flush kills the instruction, so there is nothing left to hold for.
        bus.stall      = !reset && !bus.flush && hazard;
        bus.stallCount = stall_count_q;

        stall_count_d = stall_count_q;
        if (bus.stall && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

endmodule
